// File: rtl/tcpc_pkg.sv
`default_nettype none
// tcpc_pkg: TRANSMIT type codes, ALERT bit positions and sequencer states for tcpc_tx_ctrl.
// Rev 1.0
package tcpc_pkg;

   localparam logic [2:0] TX_SOP         = 3'd0;
   localparam logic [2:0] TX_SOP_P       = 3'd1;
   localparam logic [2:0] TX_SOP_PP      = 3'd2;
   localparam logic [2:0] TX_DBG_P       = 3'd3;
   localparam logic [2:0] TX_DBG_PP      = 3'd4;
   localparam logic [2:0] TX_HARD_RESET  = 3'd5;
   localparam logic [2:0] TX_CABLE_RESET = 3'd6;
   localparam logic [2:0] TX_BIST        = 3'd7;

   localparam int ALERT_TX_FAILED    = 4;
   localparam int ALERT_TX_DISCARDED = 5;
   localparam int ALERT_TX_SUCCESS   = 6;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      MSG_SEND      = 3'd1,
      MSG_WAIT_DONE = 3'd2,
      MSG_WAIT_CRC  = 3'd3,
      RST_SEND      = 3'd4,
      RST_WAIT      = 3'd5,
      BIST_WAIT     = 3'd6,
      REPORT        = 3'd7
   } tx_state_t;

   function automatic logic is_msg_type(input logic [2:0] t);
      case (t)
         TX_SOP, TX_SOP_P, TX_SOP_PP, TX_DBG_P, TX_DBG_PP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_reset_type(input logic [2:0] t);
      return (t == TX_HARD_RESET) || (t == TX_CABLE_RESET);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tcpc_timer.sv
`default_nettype none
// tcpc_timer: loadable down-counter; expire is high for the single cycle the count sits at 1.
// Rev 1.0
module tcpc_timer #(
   parameter int TIMER_W = 13
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               clear,
   input  logic [TIMER_W-1:0] value,
   output logic               expire
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - TIMER_W'(1);
      end
   end

   assign expire = (count == TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/tcpc_tx_ctrl.sv
`default_nettype none
// tcpc_tx_ctrl: TRANSMIT request sequencer - message retry loop, Hard/Cable Reset, BIST carrier.
// Rev 1.0
module tcpc_tx_ctrl
   import tcpc_pkg::*;
#(
   parameter int CRC_TIMEOUT = 1000,
   parameter int HR_TIMEOUT  = 5000,
   parameter int TIMER_W     = 13
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  TRANSMIT,
   input  logic        transmit_wr,
   input  logic        rx_busy,
   input  logic        hard_reset_rx,
   input  logic        phy_tx_done,
   input  logic        goodcrc,
   input  logic        PHY_Stop_Attempting_Reset,
   output logic        phy_tx_start,
   output logic [2:0]  phy_tx_sop,
   output logic        hardReset,
   output logic        cableReset,
   output logic [15:0] alert_set,
   output logic        busy
);

   tx_state_t          state, state_nxt;
   logic [1:0]         attempts_left, attempts_nxt;
   logic               start_nxt, hr_nxt, cr_nxt, busy_nxt;
   logic [2:0]         sop_nxt;
   logic [15:0]        alert_nxt;
   logic               tmr_load, tmr_clear, tmr_expire;
   logic [TIMER_W-1:0] tmr_value;
   logic               go_rst;
   logic [2:0]         wr_type;
   logic               wr_reset;
   logic               abortable;
   logic               unused_transmit;

   assign wr_type         = TRANSMIT[2:0];
   assign wr_reset        = transmit_wr && is_reset_type(wr_type);
   assign abortable       = state inside {MSG_SEND, MSG_WAIT_DONE, MSG_WAIT_CRC, BIST_WAIT};
   assign unused_transmit = ^{TRANSMIT[7:6], TRANSMIT[3]};

   tcpc_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk    (CLK),
      .rst_n  (reset),
      .load   (tmr_load),
      .clear  (tmr_clear),
      .value  (tmr_value),
      .expire (tmr_expire)
   );

   always_comb begin
      state_nxt    = state;
      attempts_nxt = attempts_left;
      start_nxt    = 1'b0;
      sop_nxt      = phy_tx_sop;
      hr_nxt       = 1'b0;
      cr_nxt       = 1'b0;
      alert_nxt    = '0;
      tmr_load     = 1'b0;
      tmr_clear    = 1'b0;
      tmr_value    = TIMER_W'(CRC_TIMEOUT);
      go_rst       = 1'b0;

      case (state)
         IDLE, REPORT: begin
            state_nxt = IDLE;
            if (transmit_wr) begin
               if (is_msg_type(wr_type)) begin
                  if (rx_busy) begin
                     state_nxt = REPORT;
                     alert_nxt[ALERT_TX_DISCARDED] = 1'b1;
                  end else begin
                     state_nxt    = MSG_SEND;
                     attempts_nxt = TRANSMIT[5:4];
                     start_nxt    = 1'b1;
                     sop_nxt      = wr_type;
                  end
               end else if (wr_type == TX_BIST) begin
                  state_nxt = BIST_WAIT;
                  start_nxt = 1'b1;
                  sop_nxt   = wr_type;
               end else begin
                  go_rst = 1'b1;
               end
            end
         end
         MSG_SEND: state_nxt = MSG_WAIT_DONE;
         MSG_WAIT_DONE: begin
            if (phy_tx_done) begin
               tmr_load  = 1'b1;
               state_nxt = MSG_WAIT_CRC;
            end
         end
         MSG_WAIT_CRC: begin
            // goodcrc is checked first so a reply on the expiry cycle still counts
            if (goodcrc) begin
               state_nxt = REPORT;
               tmr_clear = 1'b1;
               alert_nxt[ALERT_TX_SUCCESS] = 1'b1;
            end else if (tmr_expire) begin
               if (attempts_left != 2'd0) begin
                  attempts_nxt = attempts_left - 2'd1;
                  state_nxt    = MSG_SEND;
                  start_nxt    = 1'b1;
               end else begin
                  state_nxt = REPORT;
                  alert_nxt[ALERT_TX_FAILED] = 1'b1;
               end
            end
         end
         RST_SEND: begin
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(HR_TIMEOUT);
            state_nxt = RST_WAIT;
         end
         RST_WAIT: begin
            if (phy_tx_done) begin
               state_nxt = REPORT;
               tmr_clear = 1'b1;
               alert_nxt[ALERT_TX_SUCCESS] = 1'b1;
               alert_nxt[ALERT_TX_FAILED]  = 1'b1;
            end else if (PHY_Stop_Attempting_Reset || tmr_expire) begin
               state_nxt = REPORT;
               tmr_clear = 1'b1;
               alert_nxt[ALERT_TX_FAILED] = 1'b1;
            end
         end
         BIST_WAIT: begin
            if (phy_tx_done) begin
               state_nxt = REPORT;
               alert_nxt[ALERT_TX_SUCCESS] = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Aborts override whatever the in-flight request would have done this cycle
      if (abortable && (wr_reset || hard_reset_rx)) begin
         state_nxt = REPORT;
         start_nxt = 1'b0;
         tmr_load  = 1'b0;
         tmr_clear = 1'b1;
         alert_nxt = '0;
         alert_nxt[ALERT_TX_DISCARDED] = 1'b1;
         go_rst    = wr_reset;
      end

      if (go_rst) begin
         state_nxt = RST_SEND;
         start_nxt = 1'b1;
         sop_nxt   = wr_type;
         hr_nxt    = (wr_type == TX_HARD_RESET);
         cr_nxt    = (wr_type == TX_CABLE_RESET);
      end

      busy_nxt = !(state_nxt inside {IDLE, REPORT});
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         attempts_left <= 2'd0;
         phy_tx_start  <= 1'b0;
         phy_tx_sop    <= 3'd0;
         hardReset     <= 1'b0;
         cableReset    <= 1'b0;
         alert_set     <= 16'd0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         attempts_left <= attempts_nxt;
         phy_tx_start  <= start_nxt;
         phy_tx_sop    <= sop_nxt;
         hardReset     <= hr_nxt;
         cableReset    <= cr_nxt;
         alert_set     <= alert_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcpc_tx_ctrl.sv
`default_nettype none
// tb_tcpc_tx_ctrl: directed and randomized transactions checked against a transaction-level outcome model.
// Rev 1.0
module tb_tcpc_tx_ctrl;

   localparam int CRC_T = 8;
   localparam int HR_T  = 20;

   logic        CLK = 1'b0;
   logic        reset;
   logic [7:0]  TRANSMIT;
   logic        transmit_wr, rx_busy, hard_reset_rx, phy_tx_done, goodcrc, stop_rst;
   logic        phy_tx_start;
   logic [2:0]  phy_tx_sop;
   logic        hardReset, cableReset;
   logic [15:0] alert_set;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int n_start = 0, n_hr = 0, n_cr = 0, n_alert = 0;

   tcpc_tx_ctrl #(.CRC_TIMEOUT(CRC_T), .HR_TIMEOUT(HR_T), .TIMER_W(13)) dut (
      .CLK                       (CLK),
      .reset                     (reset),
      .TRANSMIT                  (TRANSMIT),
      .transmit_wr               (transmit_wr),
      .rx_busy                   (rx_busy),
      .hard_reset_rx             (hard_reset_rx),
      .phy_tx_done               (phy_tx_done),
      .goodcrc                   (goodcrc),
      .PHY_Stop_Attempting_Reset (stop_rst),
      .phy_tx_start              (phy_tx_start),
      .phy_tx_sop                (phy_tx_sop),
      .hardReset                 (hardReset),
      .cableReset                (cableReset),
      .alert_set                 (alert_set),
      .busy                      (busy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (phy_tx_start) n_start++;
      if (hardReset) n_hr++;
      if (cableReset) n_cr++;
      if (alert_set != 16'd0) n_alert++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Outcome model: what a message request must produce, from retry count and goodcrc attempt
   function automatic int model_attempts(input int retries, input int crc_attempt);
      if (crc_attempt >= 1 && crc_attempt <= retries + 1) return crc_attempt;
      return retries + 1;
   endfunction

   function automatic logic [15:0] model_msg_alert(input int retries, input int crc_attempt);
      if (crc_attempt >= 1 && crc_attempt <= retries + 1) return 16'h0040;
      return 16'h0010;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_tx(input logic [7:0] tx);
      TRANSMIT    = tx;
      transmit_wr = 1'b1;
      tick();
      transmit_wr = 1'b0;
   endtask

   task automatic run_msg(input logic [7:0] tx, input int crc_attempt, input int crc_delay);
      int retries  = int'(tx[5:4]);
      int attempts = model_attempts(retries, crc_attempt);
      int s0       = n_start;
      int lat;
      write_tx(tx);
      chk("msg_start_at_n1", phy_tx_start, 1);
      chk("msg_busy", busy, 1);
      chk("msg_sop", phy_tx_sop, tx[2:0]);
      for (int a = 1; a <= attempts; a++) begin
         lat = $urandom_range(1, 3);
         repeat (lat) tick();
         phy_tx_done = 1'b1;
         tick();
         phy_tx_done = 1'b0;
         if (a == crc_attempt) begin
            repeat (crc_delay - 1) tick();
            goodcrc = 1'b1;
            tick();
            goodcrc = 1'b0;
         end else begin
            repeat (CRC_T - 1) tick();
            chk("crc_expiry_cycle_busy", busy, 1);
            tick();
            if (a < attempts) chk("retry_start", phy_tx_start, 1);
         end
      end
      chk("msg_alert", alert_set, model_msg_alert(retries, crc_attempt));
      chk("msg_busy_fall", busy, 0);
      tick();
      chk("msg_alert_one_cycle", alert_set, 0);
      chk("msg_start_count", n_start - s0, attempts);
   endtask

   // mode 0: phy_tx_done, 1: PHY stops attempting, 2: HR timeout
   task automatic run_rst(input logic [7:0] tx, input int mode, input int lat);
      int h0 = n_hr;
      int c0 = n_cr;
      logic is_hr = (tx[2:0] == 3'd5);
      logic [15:0] exp_alert = (mode == 0) ? 16'h0050 : 16'h0010;
      write_tx(tx);
      chk("rst_start_at_n1", phy_tx_start, 1);
      chk("rst_pulse_at_n1", {hardReset, cableReset}, is_hr ? 2'b10 : 2'b01);
      chk("rst_sop", phy_tx_sop, tx[2:0]);
      if (mode == 2) begin
         repeat (HR_T) tick();
         chk("hr_expiry_cycle_busy", busy, 1);
         tick();
      end else begin
         repeat (lat) tick();
         if (mode == 0) phy_tx_done = 1'b1;
         else stop_rst = 1'b1;
         tick();
         phy_tx_done = 1'b0;
         stop_rst    = 1'b0;
      end
      chk("rst_alert", alert_set, exp_alert);
      chk("rst_busy_fall", busy, 0);
      tick();
      chk("rst_alert_one_cycle", alert_set, 0);
      chk("hardreset_count", n_hr - h0, is_hr ? 1 : 0);
      chk("cablereset_count", n_cr - c0, is_hr ? 0 : 1);
   endtask

   task automatic run_discard(input logic [7:0] tx);
      rx_busy = 1'b1;
      write_tx(tx);
      rx_busy = 1'b0;
      chk("discard_alert", alert_set, 16'h0020);
      chk("discard_no_start", phy_tx_start, 0);
      chk("discard_busy", busy, 0);
      tick();
      chk("discard_alert_one_cycle", alert_set, 0);
   endtask

   initial begin
      int kind, r, t, a0, s0;
      logic [7:0] tx;
      reset = 1'b1;
      TRANSMIT = 8'h00;
      transmit_wr = 0; rx_busy = 0; hard_reset_rx = 0; phy_tx_done = 0; goodcrc = 0; stop_rst = 0;
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {phy_tx_start, phy_tx_sop, hardReset, cableReset, alert_set, busy}, 0);
      @(negedge CLK) reset = 1'b1;
      tick();
      chk("post_reset_busy", busy, 0);

      run_msg(8'h30, 1, 3);
      run_msg(8'h10, 0, 1);
      run_rst(8'h05, 0, 4);
      run_rst(8'h05, 1, 4);
      run_rst(8'h06, 2, 1);
      run_discard(8'h02);

      // goodcrc and a Cable Reset write on the same cycle: the reset wins
      write_tx(8'h00);
      repeat (2) tick();
      phy_tx_done = 1'b1; tick(); phy_tx_done = 1'b0;
      repeat (2) tick();
      goodcrc = 1'b1;
      write_tx(8'h06);
      goodcrc = 1'b0;
      chk("preempt_alert", alert_set, 16'h0020);
      chk("preempt_cablereset", {hardReset, cableReset}, 2'b01);
      chk("preempt_start", phy_tx_start, 1);
      chk("preempt_busy", busy, 1);
      repeat (4) tick();
      phy_tx_done = 1'b1; tick(); phy_tx_done = 1'b0;
      chk("preempt_completion", alert_set, 16'h0050);
      tick();

      // Hard Reset received from the partner aborts a message
      write_tx(8'h21);
      repeat (2) tick();
      phy_tx_done = 1'b1; tick(); phy_tx_done = 1'b0;
      a0 = n_alert; s0 = n_start;
      hard_reset_rx = 1'b1; tick(); hard_reset_rx = 1'b0;
      chk("hr_rx_abort_alert", alert_set, 16'h0020);
      chk("hr_rx_abort_busy", busy, 0);
      repeat (CRC_T + 3) tick();
      chk("hr_rx_no_retry", n_start - s0, 0);
      chk("hr_rx_single_alert", n_alert - a0, 1);

      // BIST carrier, with an ignored message write while it runs
      s0 = n_start;
      write_tx(8'h07);
      chk("bist_start", phy_tx_start, 1);
      chk("bist_sop", phy_tx_sop, 7);
      tick();
      write_tx(8'h02);
      repeat (3) tick();
      phy_tx_done = 1'b1; tick(); phy_tx_done = 1'b0;
      chk("bist_alert", alert_set, 16'h0040);
      chk("bist_start_count", n_start - s0, 1);
      tick();

      // Asynchronous reset in MSG_WAIT_CRC
      write_tx(8'h30);
      repeat (2) tick();
      phy_tx_done = 1'b1; tick(); phy_tx_done = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outputs", {phy_tx_start, phy_tx_sop, hardReset, cableReset, alert_set, busy}, 0);
      @(negedge CLK);
      @(negedge CLK) reset = 1'b1;
      a0 = n_alert;
      repeat (CRC_T + 4) tick();
      chk("no_alert_after_reset", n_alert - a0, 0);
      run_msg(8'h30, 1, 3);

      for (int i = 0; i < 12; i++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            r = $urandom_range(0, 3);
            t = $urandom_range(0, 4);
            run_msg({2'b00, 2'(r), 1'b0, 3'(t)}, $urandom_range(0, r + 2), $urandom_range(1, CRC_T));
         end else if (kind == 1) begin
            tx = 8'($urandom_range(0, 255));
            tx[2:0] = 3'($urandom_range(5, 6));
            run_rst(tx, $urandom_range(0, 2), $urandom_range(1, HR_T - 2));
         end else begin
            tx = 8'($urandom_range(0, 255));
            tx[2:0] = 3'($urandom_range(0, 4));
            run_discard(tx);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tcpc_tx_ctrl.md
# tcpc_tx_ctrl

Transmit-request sequencer for the TCPC. Accepts writes to the TRANSMIT register, drives the PHY transmitter for SOP* messages, BIST carrier, Hard Reset and Cable Reset. Runs the GoodCRC wait/retry loop and generates the hardReset/cableReset pulses consumed by the reset block. Reports completion to the ALERT register as one-cycle set pulses.

## Interface
Parameters:
- CRC_TIMEOUT, 1000: cycles from phy_tx_done to GoodCRC timeout (tCRCReceive).
- HR_TIMEOUT, 5000: cycles allowed for Hard/Cable Reset completion (tHardResetComplete).
- TIMER_W, 13: timer width; must hold max(CRC_TIMEOUT, HR_TIMEOUT).

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- TRANSMIT  in  8  TRANSMIT register; [2:0] type (0–4 SOP*, 5 Hard Reset, 6 Cable Reset, 7 BIST carrier); [5:4] retry count.
- transmit_wr  in  1  one-cycle pulse: TRANSMIT was written.
- rx_busy  in  1  PHY is receiving a message.
- hard_reset_rx  in  1  pulse: Hard Reset received from port partner.
- phy_tx_done  in  1  pulse: PHY finished sending the current frame or ordered set.
- goodcrc  in  1  pulse: matching GoodCRC received.
- PHY_Stop_Attempting_Reset  in  1  PHY abandons the reset transmission.
- phy_tx_start  out  1  pulse: start transmission.
- phy_tx_sop  out  3  type code for the transmission; held while busy.
- hardReset  out  1  one-cycle pulse to the reset block.
- cableReset  out  1  one-cycle pulse to the reset block.
- alert_set  out  16  one-cycle set vector OR-ed into ALERT. Bit 4 = TxFailed, bit 5 = TxDiscarded, bit 6 = TxSuccess. Other bits are always 0.
- busy  out  1  request in progress.

## Operation
- States: IDLE, MSG_SEND, MSG_WAIT_DONE, MSG_WAIT_CRC, RST_SEND, RST_WAIT, BIST_WAIT, REPORT.
- IDLE + transmit_wr:
  - Type 0–4: if rx_busy, report TxDiscarded. Otherwise go to MSG_SEND with attempts_left = TRANSMIT[5:4].
  - Type 5/6: go to RST_SEND.
  - Type 7: send carrier, go to BIST_WAIT.
- MSG_SEND: pulse phy_tx_start, then MSG_WAIT_DONE. phy_tx_done loads the CRC timer and moves to MSG_WAIT_CRC.
- MSG_WAIT_CRC:
  - goodcrc → TxSuccess. goodcrc arriving on the expiry cycle counts as success.
  - Expiry with attempts_left > 0 → decrement attempts_left, back to MSG_SEND.
  - Expiry with attempts_left = 0 → TxFailed.
  - Total attempts = retries + 1.
- RST_SEND: pulse hardReset (type 5) or cableReset (type 6) together with phy_tx_start, load HR timer, go to RST_WAIT.
- RST_WAIT:
  - phy_tx_done → TxSuccess and TxFailed both set (TCPCI Hard Reset completion).
  - PHY_Stop_Attempting_Reset or HR expiry → TxFailed only.
- BIST_WAIT: phy_tx_done → TxSuccess. No retry, no timer.
- REPORT: alert_set pulse, then IDLE.
- transmit_wr while busy:
  - Type 5/6 preempts any message or BIST request: pending message reported TxDiscarded, and RST_SEND is entered in the same transition.
  - Types 0–4 and 7 are ignored; no alert.
  - Type 5/6 during RST_* is ignored.
- hard_reset_rx in any MSG_*/BIST state: abort, report TxDiscarded. In RST_*: ignored.
- Simultaneous goodcrc and preempting reset write: the reset wins and the message is reported TxDiscarded.

## Timing
- Async reset: state IDLE, timers 0, all outputs 0 immediately. No alert is generated for a request aborted by reset.
- All outputs are registered.
- Message path:
  - transmit_wr at cycle N (IDLE) → busy = 1 and phy_tx_start = 1 at N+1.
  - Retry phy_tx_start occurs 1 cycle after timer expiry.
- Reset path: transmit_wr at N → hardReset/cableReset and phy_tx_start at N+1.
- Timer: loaded on the phy_tx_done cycle; expires CRC_TIMEOUT cycles later.
- Completion: alert_set pulses the cycle after the terminating event. busy falls in that same cycle, and transmit_wr is accepted from that cycle on.
- phy_tx_sop updates with phy_tx_start.

## Structure
- Package tcpc_pkg:
  - TRANSMIT type codes (SOP, SOP', SOP'', DBG', DBG'', HARD_RESET, CABLE_RESET, BIST).
  - ALERT bit indices (TX_FAILED = 4, TX_DISCARDED = 5, TX_SUCCESS = 6).
  - State enum.
- Sub-module tcpc_timer: loadable TIMER_W down-counter with a one-cycle expire pulse and a clear input. One instance serves both CRC and HR timeouts.

## Test plan
Bench parameters: CRC_TIMEOUT = 8, HR_TIMEOUT = 20.
- SOP write TRANSMIT = 8'h30 (3 retries), goodcrc 3 cycles after the first phy_tx_done → one phy_tx_start; alert_set = 16'h0040.
- TRANSMIT = 8'h10, no goodcrc → exactly 2 phy_tx_start pulses, each followed by an 8-cycle wait; then alert_set = 16'h0010.
- TRANSMIT = 8'h05, phy_tx_done after 4 cycles → hardReset pulse at N+1; alert_set = 16'h0050. Repeat with PHY_Stop_Attempting_Reset instead → alert_set = 16'h0010.
- SOP write with rx_busy = 1 → no phy_tx_start; alert_set = 16'h0020 next cycle.
- SOP in MSG_WAIT_CRC, then write TRANSMIT = 8'h06 in the same cycle as goodcrc → alert_set = 16'h0020; cableReset pulse next cycle; later completion with phy_tx_done → 16'h0050.
- reset low during MSG_WAIT_CRC → all outputs 0 asynchronously; no alert after release; next SOP write behaves as the first scenario.
